// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle between the async FIFO write controller and its environment.
// The slave modport is the controller; the master modport is the producer/synchronizer side.
interface fifo_wr_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W:0]   rd_gray_sync;
    logic              wr_ram_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_gray;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   wr_level;
    logic              overflow;

    modport master (
        output wr_en, rd_gray_sync,
        input  wr_ram_en, wr_addr, wr_gray, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  wr_en, rd_gray_sync,
        output wr_ram_en, wr_addr, wr_gray, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: binary/Gray write pointers, RAM write strobe,
// and full / almost-full / level / sticky-overflow flags against the synced read pointer.
module fifo_wr_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6
) (
    input  logic          clk,
    input  logic          reset,
    fifo_wr_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(AF_THRESH);

    logic [ADDR_W:0] wr_bin;
    logic [ADDR_W:0] wr_bin_next;
    logic [ADDR_W:0] gray_next;
    logic [ADDR_W:0] rd_bin;
    logic [ADDR_W:0] full_code;
    logic [ADDR_W:0] level_next;
    logic            push;

    assign push          = bus.wr_en & ~bus.full & ~reset;
    assign bus.wr_ram_en = push;
    assign bus.wr_addr   = wr_bin[ADDR_W-1:0];

    assign wr_bin_next = wr_bin + {{ADDR_W{1'b0}}, push};
    assign gray_next   = wr_bin_next ^ (wr_bin_next >> 1);

    always_comb begin
        // NOTE: default every bit first so no path through this block can infer a latch.
        rd_bin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rd_bin[i] = ^(bus.rd_gray_sync >> i);
        end
    end

    // Full means the write pointer is one lap ahead: Gray top two bits inverted, rest equal.
    assign full_code  = {~bus.rd_gray_sync[ADDR_W:ADDR_W-1], bus.rd_gray_sync[ADDR_W-2:0]};
    assign level_next = wr_bin_next - rd_bin;

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: plain flops only (no storage array), so all state is cleared on reset.
            wr_bin          <= '0;
            bus.wr_gray     <= '0;
            bus.full        <= 1'b0;
            bus.almost_full <= 1'b0;
            bus.wr_level    <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            wr_bin          <= wr_bin_next;
            bus.wr_gray     <= gray_next;
            bus.full        <= (gray_next == full_code);
            bus.almost_full <= (level_next >= AF_LEVEL);
            bus.wr_level    <= level_next;
            bus.overflow    <= bus.overflow | (bus.wr_en & bus.full);
        end
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed steps plus a randomized phase, all
// checked against a counting model (total pushes and total reads as plain integers).
module tb_fifo_wr_ctrl;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;

    logic clk = 1'b0;
    logic reset;

    fifo_wr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_THRESH(AF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts of accepted writes and of reads presented, plus flags.
    int m_wr   = 0;
    int m_rd   = 0;
    int m_lvl  = 0;
    bit m_full = 1'b0;
    bit m_af   = 1'b0;
    bit m_ovf  = 1'b0;
    bit primed = 1'b0;

    function automatic logic [ADDR_W:0] to_gray(input int count);
        int b;
        b = count % (2 * DEPTH);
        return (ADDR_W + 1)'(b ^ (b / 2));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, clock, update model, check registers.
    task automatic cycle(input logic wr, input int rd_cnt);
        bit exp_push;
        int lvl;
        bus.wr_en        = wr;
        bus.rd_gray_sync = to_gray(rd_cnt);
        #3;
        exp_push = wr && !m_full && !reset;
        check("wr_ram_en", 32'(bus.wr_ram_en), 32'(exp_push));
        if (primed) check("wr_addr_pre", 32'(bus.wr_addr), 32'(m_wr % DEPTH));
        @(posedge clk);
        if (reset) begin
            m_wr = 0; m_rd = 0; m_lvl = 0;
            m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        end else begin
            m_ovf = m_ovf | (wr && m_full);
            if (exp_push) m_wr++;
            m_rd   = rd_cnt;
            lvl    = m_wr - m_rd;
            m_lvl  = lvl;
            m_full = (lvl == DEPTH);
            m_af   = (lvl >= AF);
        end
        primed = 1'b1;
        #1;
        check("wr_gray",     32'(bus.wr_gray),     32'(to_gray(m_wr)));
        check("wr_addr",     32'(bus.wr_addr),     32'(m_wr % DEPTH));
        check("wr_level",    32'(bus.wr_level),    32'(m_lvl));
        check("full",        32'(bus.full),        32'(m_full));
        check("almost_full", 32'(bus.almost_full), 32'(m_af));
        check("overflow",    32'(bus.overflow),    32'(m_ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W:0] prev_gray;
        logic [ADDR_W:0] exp_gray;
        bit saw_wrap;
        int adv;
        bit wr;

        // Reset held two cycles with a pending write.
        reset = 1'b1;
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        check("rst_wr_gray", 32'(bus.wr_gray), 32'd0);
        check("rst_full",    32'(bus.full),    32'd0);
        reset = 1'b0;

        // Fill from empty: first push gives Gray 0001, eighth gives 1100 and full.
        cycle(1'b1, 0);
        check("first_gray", 32'(bus.wr_gray), 32'h1);
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 0);
            if (i == 4) check("af_at_6", 32'(bus.almost_full), 32'd1);
        end
        check("fill_gray",  32'(bus.wr_gray),  32'hC);
        check("fill_full",  32'(bus.full),     32'd1);
        check("fill_level", 32'(bus.wr_level), 32'd8);

        // Writes while full are dropped and latch overflow.
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        check("ovf_gray", 32'(bus.wr_gray),  32'hC);
        check("ovf_flag", 32'(bus.overflow), 32'd1);

        // Drain release: read pointer jumps to 3.
        cycle(1'b0, 3);
        check("drain_full",  32'(bus.full),        32'd0);
        check("drain_level", 32'(bus.wr_level),    32'd5);
        check("drain_af",    32'(bus.almost_full), 32'd0);
        check("ovf_sticky",  32'(bus.overflow),    32'd1);
        cycle(1'b1, 3);
        check("refill_af", 32'(bus.almost_full), 32'd1);

        // Wrap-around with the read pointer trailing by two.
        cycle(1'b0, m_wr - 2);
        saw_wrap  = 1'b0;
        prev_gray = bus.wr_gray;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, m_wr - 1);
            check("wrap_level", 32'(bus.wr_level), 32'd2);
            if (prev_gray == 4'b1000 && bus.wr_gray == 4'b0000) saw_wrap = 1'b1;
            prev_gray = bus.wr_gray;
        end
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Randomized traffic: write-heavy then read-heavy, reads never pass writes.
        for (int i = 0; i < 200; i++) begin
            wr  = (i < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            adv = (i < 100) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
            if (m_rd + adv > m_wr) adv = m_wr - m_rd;
            cycle(wr, m_rd + adv);
        end

        // Bring level to exactly 7, then push and read in the same cycle.
        for (int i = 0; i < 12; i++) begin
            if (m_lvl < 7) cycle(1'b1, m_rd);
        end
        if (m_lvl == DEPTH) cycle(1'b0, m_rd + 1);
        check("pre_sim_level", 32'(bus.wr_level), 32'd7);
        exp_gray = to_gray(m_wr + 1);
        cycle(1'b1, m_rd + 1);
        check("sim_level", 32'(bus.wr_level), 32'd7);
        check("sim_full",  32'(bus.full),     32'd0);
        check("sim_gray",  32'(bus.wr_gray),  32'(exp_gray));

        // Mid-operation reset with a nonzero read pointer clears everything.
        reset = 1'b1;
        cycle(1'b1, 5);
        reset = 1'b0;
        check("mid_rst_level", 32'(bus.wr_level), 32'd0);
        check("mid_rst_ovf",   32'(bus.overflow), 32'd0);
        cycle(1'b1, 0);
        check("post_rst_gray", 32'(bus.wr_gray), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
